// File: rtl/motor_pkg.sv
// Shared types for the motor power-stage arbiter: FSM state encoding and drive direction.
package motor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: the search starts at the index just after ptr and wraps.
module rr_arbiter
   import motor_pkg::*;
#(
   parameter int NCH = 4
) (
   input  logic [NCH-1:0]         req,
   input  logic [$clog2(NCH)-1:0] ptr,
   output logic [NCH-1:0]         gnt_oh,
   output logic [$clog2(NCH)-1:0] gnt_idx,
   output logic                   gnt_vld
);

   localparam int IW = $clog2(NCH);

   logic [IW-1:0] cand_s;

   // First requester found walking forward from ptr+1 wins.
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      cand_s  = '0;
      for (int k = 1; k <= NCH; k++) begin
         cand_s = IW'((int'(ptr) + k) % NCH);
         if (!gnt_vld && req[cand_s]) begin
            gnt_vld         = 1'b1;
            gnt_idx         = cand_s;
            gnt_oh[cand_s]  = 1'b1;
         end else begin
            gnt_vld = gnt_vld;
         end
      end
   end

endmodule

// File: rtl/motor_arbiter.sv
// Shares one motor power stage among NCH actuators with dead time and limit-switch stops.
// Optional drive timeout fault enabled by defining MOTOR_ARB_TIMEOUT_EN.
module motor_arbiter
   import motor_pkg::*;
#(
   parameter int NCH         = 4,
   parameter int DEAD_CYC    = 8,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NCH-1:0]         activate,
   input  logic [NCH-1:0]         up_limit,
   input  logic [NCH-1:0]         dn_limit,
   input  logic [NCH-1:0]         fault_clr,
   output logic                   motor_up,
   output logic                   motor_dn,
   output logic [$clog2(NCH)-1:0] sel,
   output logic                   busy,
   output logic [NCH-1:0]         done,
   output logic [NCH-1:0]         fault
);

   localparam int IW = $clog2(NCH);
   localparam int SW = $clog2(DEAD_CYC) + 1;

   state_t          state_r;
   logic            dir_r;
   logic [SW-1:0]   settle_cnt_r;
   logic [IW-1:0]   ptr_r;
   logic [IW-1:0]   sel_r;
   logic [NCH-1:0]  pending_r;
   logic [NCH-1:0]  fault_r;
   logic [NCH-1:0]  done_r;
   logic            motor_up_r;
   logic            motor_dn_r;
   logic            busy_r;

   logic [NCH-1:0]  gnt_oh_s;
   logic [IW-1:0]   gnt_idx_s;
   logic            gnt_vld_s;
   logic            grant_s;
   logic            bad_lim_s;
   logic            tgt_hit_s;
   logic            timeout_s;
   logic [NCH-1:0]  svc_mask_s;
   logic [NCH-1:0]  fault_set_s;

`ifdef MOTOR_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;
   logic [TW-1:0]   drv_cnt_r;
`endif

   rr_arbiter #(.NCH(NCH)) u_rr (
      .req     (pending_r),
      .ptr     (ptr_r),
      .gnt_oh  (gnt_oh_s),
      .gnt_idx (gnt_idx_s),
      .gnt_vld (gnt_vld_s)
   );

   // Grant qualification, target-limit detection and fault set sources.
   always_comb begin
      grant_s    = (state_r == ST_IDLE) && gnt_vld_s;
      bad_lim_s  = up_limit[gnt_idx_s] && dn_limit[gnt_idx_s];
      tgt_hit_s  = (dir_r == DIR_DN) ? dn_limit[sel_r] : up_limit[sel_r];
      svc_mask_s = (state_r != ST_IDLE) ? (NCH'(1) << sel_r) : '0;
`ifdef MOTOR_ARB_TIMEOUT_EN
      timeout_s  = (state_r == ST_RUN) && !tgt_hit_s && (drv_cnt_r == TW'(TIMEOUT_CYC - 1));
`else
      timeout_s  = 1'b0;
`endif
      if (grant_s && bad_lim_s) begin
         fault_set_s = gnt_oh_s;
      end else if (timeout_s) begin
         fault_set_s = NCH'(1) << sel_r;
      end else begin
         fault_set_s = '0;
      end
   end

   // Pending requests: a grant clears its bit even if activate is still high that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r <= '0;
      end else begin
         pending_r <= (pending_r | (activate & ~fault_r & ~svc_mask_s))
                      & ~(grant_s ? gnt_oh_s : '0);
      end
   end

   // Sticky fault flags; a new fault wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_r <= '0;
      end else begin
         fault_r <= (fault_r & ~fault_clr) | fault_set_s;
      end
   end

   // Service FSM with registered drive, select, busy and done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         dir_r        <= DIR_UP;
         settle_cnt_r <= '0;
         ptr_r        <= IW'(NCH - 1);
         sel_r        <= '0;
         done_r       <= '0;
         motor_up_r   <= 1'b0;
         motor_dn_r   <= 1'b0;
         busy_r       <= 1'b0;
`ifdef MOTOR_ARB_TIMEOUT_EN
         drv_cnt_r    <= '0;
`endif
      end else begin
         done_r <= '0;
         case (state_r)
            ST_IDLE: begin
               motor_up_r <= 1'b0;
               motor_dn_r <= 1'b0;
               if (gnt_vld_s) begin
                  sel_r <= gnt_idx_s;
                  if (bad_lim_s) begin
                     ptr_r  <= gnt_idx_s;
                     busy_r <= 1'b0;
                  end else begin
                     dir_r        <= up_limit[gnt_idx_s] ? DIR_DN : DIR_UP;
                     settle_cnt_r <= '0;
                     state_r      <= ST_SETTLE;
                     busy_r       <= 1'b1;
                  end
               end else begin
                  busy_r <= 1'b0;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt_r == SW'(DEAD_CYC - 1)) begin
                  settle_cnt_r <= '0;
                  motor_up_r   <= (dir_r == DIR_UP);
                  motor_dn_r   <= (dir_r == DIR_DN);
                  state_r      <= ST_RUN;
`ifdef MOTOR_ARB_TIMEOUT_EN
                  drv_cnt_r    <= '0;
`endif
               end else begin
                  settle_cnt_r <= settle_cnt_r + SW'(1);
                  motor_up_r   <= 1'b0;
                  motor_dn_r   <= 1'b0;
               end
            end
            ST_RUN: begin
               if (tgt_hit_s) begin
                  motor_up_r <= 1'b0;
                  motor_dn_r <= 1'b0;
                  done_r     <= NCH'(1) << sel_r;
                  state_r    <= ST_STOP;
               end else if (timeout_s) begin
                  // Timed-out move: no completion pulse, fault flagged instead.
                  motor_up_r <= 1'b0;
                  motor_dn_r <= 1'b0;
                  ptr_r      <= sel_r;
                  busy_r     <= 1'b0;
                  state_r    <= ST_IDLE;
               end else begin
`ifdef MOTOR_ARB_TIMEOUT_EN
                  drv_cnt_r  <= drv_cnt_r + TW'(1);
`endif
               end
            end
            ST_STOP: begin
               ptr_r   <= sel_r;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               motor_up_r <= 1'b0;
               motor_dn_r <= 1'b0;
               busy_r     <= 1'b0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

   assign motor_up = motor_up_r;
   assign motor_dn = motor_dn_r;
   assign sel      = sel_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign fault    = fault_r;

endmodule

// File: doc/motor_arbiter.md
MOTOR_ARBITER -- requirements
Module: motor_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4, number of actuators sharing one motor power stage.
REQ-002 SHALL have parameter DEAD_CYC, default 8, dead-time cycles between select change and motor drive.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000, maximum drive cycles before a fault is declared.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port activate, input, NCH, per-actuator move request (level, sampled every cycle).
REQ-007 SHALL have port up_limit, input, NCH, per-actuator top limit switch.
REQ-008 SHALL have port dn_limit, input, NCH, per-actuator bottom limit switch.
REQ-009 SHALL have port fault_clr, input, NCH, per-actuator fault clear pulse.
REQ-010 SHALL have port motor_up, output, 1, drive up to shared power stage.
REQ-011 SHALL have port motor_dn, output, 1, drive down to shared power stage.
REQ-012 SHALL have port sel, output, $clog2(NCH), power-stage mux select (granted actuator).
REQ-013 SHALL have ports busy (output, 1, not IDLE), done (output, NCH, one-cycle completion pulse) and fault (output, NCH, sticky fault flags).

Function
REQ-014 SHALL hold a pending bit per actuator, set on any cycle activate[i]=1 while i is not the channel in service and fault[i]=0; cleared at grant.
REQ-015 SHALL implement states IDLE, SETTLE, RUN, STOP.
REQ-016 IDLE: if any pending, SHALL grant one round-robin starting after the last served index, register sel, clear its pending bit, go to SETTLE next cycle.
REQ-017 At grant, direction SHALL be down if up_limit[sel]=1, else up (latched for the whole move).
REQ-018 At grant, if up_limit and dn_limit both 1, SHALL set fault[sel], skip the move and return to IDLE.
REQ-019 SETTLE: SHALL count DEAD_CYC cycles with motor_up=motor_dn=0, then enter RUN asserting exactly the latched direction.
REQ-020 RUN: SHALL hold the drive until the target limit (dn_limit for down, up_limit for up) of sel is 1, then deassert drive and go to STOP.
REQ-021 STOP: SHALL pulse done[sel] for one cycle, update the round-robin pointer to sel, return to IDLE.
REQ-022 motor_up and motor_dn SHALL be registered and never be 1 simultaneously.
REQ-023 sel SHALL change only in IDLE, never while motor_up or motor_dn is 1.
REQ-024 fault_clr[i] SHALL clear fault[i]; fault_clr and a fault set in the same cycle SHALL leave fault set.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, motor_up=0, motor_dn=0, sel=0, busy=0, done=0, fault=0, pending=0, pointer=NCH-1, counters=0, including mid-RUN.

Configuration
REQ-026 With MOTOR_ARB_TIMEOUT_EN defined, a drive counter SHALL run in RUN; on reaching TIMEOUT_CYC without target limit, drive SHALL deassert, fault[sel] set, no done pulse, go to IDLE.
REQ-027 Without MOTOR_ARB_TIMEOUT_EN, no timeout counter SHALL exist, RUN waits indefinitely, and fault is set only per REQ-018.

Structure
REQ-028 Shared package motor_pkg SHALL hold the state enum and direction encoding constants.
REQ-029 Round-robin grant logic SHALL be a sub-module rr_arbiter (req vector, pointer -> one-hot/index grant).

Verification
REQ-030 ch1 activate pulse, up_limit[1]=0 -> sel=1, motor_up=1 exactly DEAD_CYC(8) cycles after SETTLE entry; up_limit[1]=1 -> motor_up=0, done[1] pulse, busy=0.
REQ-031 activate on ch0,ch2,ch3 same cycle, pointer=3 -> service order 0,2,3, each with done pulse, no overlapping drive.
REQ-032 With MOTOR_ARB_TIMEOUT_EN, ch2 limit never asserts -> drive drops after 1000 RUN cycles, fault[2]=1, later activate[2] ignored until fault_clr[2].
REQ-033 ch0 with up_limit=1 and dn_limit=1 at grant -> no drive, fault[0]=1, IDLE next cycle.
REQ-034 rst_n low mid-RUN on ch3 -> motor_up=motor_dn=0 same cycle, all pending/fault cleared, no done pulse.
REQ-035 Random activate/limit stress -> assertions: never both drive bits, sel stable while driving, drive off during SETTLE.
